// File: rtl/ad9826_config_sequencer_pkg.sv
// Shared definitions for the AD9826 configuration sequencer: register map,
// sequencer state encoding, transfer phase and result codes.
package ad9826_config_sequencer_pkg;

    localparam logic [2:0] REG_CONFIG = 3'd0;
    localparam logic [2:0] REG_MUX    = 3'd1;
    localparam logic [2:0] REG_PGA_R  = 3'd2;
    localparam logic [2:0] REG_PGA_G  = 3'd3;
    localparam logic [2:0] REG_PGA_B  = 3'd4;
    localparam logic [2:0] REG_OFS_R  = 3'd5;
    localparam logic [2:0] REG_OFS_G  = 3'd6;
    localparam logic [2:0] REG_OFS_B  = 3'd7;

    typedef enum logic [2:0] {
        IDLE,
        BOOT,
        SELECT,
        ISSUE,
        ACK,
        XFER,
        CHECK,
        FINISH
    } state_t;

    typedef enum logic {
        PH_WR,
        PH_RD
    } phase_t;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'b00,
        ERR_MISMATCH = 2'b01,
        ERR_TIMEOUT  = 2'b10
    } err_t;

    // Pull the 9-bit value for register k out of the packed 72-bit image.
    function automatic logic [8:0] reg_image(input logic [71:0] image, input logic [2:0] k);
        return image[9*k +: 9];
    endfunction

endpackage

// File: rtl/ad9826_config_sequencer_if.sv
// Request/response bus between the configuration sequencer (master) and the
// AD9826 serial controller (slave).
interface ad9826_config_sequencer_if;

    logic [2:0] address;
    logic [8:0] write_data;
    logic       write_valid;
    logic       read_start;
    logic [8:0] read_data;
    logic       busy;

    modport master (
        output address,
        output write_data,
        output write_valid,
        output read_start,
        input  read_data,
        input  busy
    );

    modport slave (
        input  address,
        input  write_data,
        input  write_valid,
        input  read_start,
        output read_data,
        output busy
    );

endinterface

// File: rtl/ad9826_config_sequencer.sv
// Programs up to eight AD9826 registers from a host image through the serial
// controller, optionally reads each one back, and reports a sticky result.
module ad9826_config_sequencer
    import ad9826_config_sequencer_pkg::*;
#(
    parameter int AUTO_START  = 1,
    parameter int TIMEOUT_CYC = 4096,
    parameter int ACK_CYC     = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start_i,
    input  logic [71:0]                   cfg_data_i,
    input  logic [7:0]                    cfg_mask_i,
    input  logic                          verify_i,
    ad9826_config_sequencer_if.master     ctrl,
    output logic                          busy_o,
    output logic                          done_o,
    output logic [1:0]                    error_o,
    output logic [2:0]                    err_addr_o
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam int AW = $clog2(ACK_CYC + 1);
    localparam logic [TW-1:0] T_LIMIT = TW'(TIMEOUT_CYC - 1);
    localparam logic [TW-1:0] T_SAT   = TW'(TIMEOUT_CYC);
    localparam logic [AW-1:0] A_LIMIT = AW'(ACK_CYC - 1);

    state_t        state;
    state_t        state_next;
    phase_t        phase;
    phase_t        phase_next;
    logic [3:0]    idx;
    logic [3:0]    idx_next;
    logic [71:0]   cfg_image;
    logic [7:0]    cfg_mask;
    logic          cfg_verify;
    logic [TW-1:0] tcnt;
    logic [AW-1:0] ack_cnt;
    logic          armed;
    logic          load_cfg;
    logic          issue;
    logic          ack_inc;
    logic          tcnt_inc;
    logic          fail;
    err_t          fail_code;

    // State register; AUTO_START parts come out of reset into BOOT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= (AUTO_START != 0) ? BOOT : IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and control strobes for the register scan and transfer handshake
    always_comb begin
        state_next = state;
        phase_next = phase;
        idx_next   = idx;
        load_cfg   = 1'b0;
        issue      = 1'b0;
        ack_inc    = 1'b0;
        tcnt_inc   = 1'b0;
        fail       = 1'b0;
        fail_code  = ERR_NONE;
        case (state)
            IDLE: begin
                if (start_i && armed) begin
                    load_cfg   = 1'b1;
                    idx_next   = 4'd0;
                    state_next = SELECT;
                end
            end
            BOOT: begin
                if (armed) begin
                    load_cfg   = 1'b1;
                    idx_next   = 4'd0;
                    state_next = SELECT;
                end
            end
            SELECT: begin
                if (idx > {1'b0, REG_OFS_B}) begin
                    state_next = FINISH;
                end else if (cfg_mask[idx[2:0]]) begin
                    if (!ctrl.busy) begin
                        phase_next = PH_WR;
                        issue      = 1'b1;
                        state_next = ISSUE;
                    end
                end else begin
                    idx_next = idx + 4'd1;
                end
            end
            ISSUE: begin
                state_next = ACK;
            end
            ACK: begin
                if (ctrl.busy) begin
                    state_next = XFER;
                end else if (ack_cnt >= A_LIMIT) begin
                    fail       = 1'b1;
                    fail_code  = ERR_TIMEOUT;
                    state_next = FINISH;
                end else begin
                    ack_inc = 1'b1;
                end
            end
            XFER: begin
                if (!ctrl.busy) begin
                    if (phase == PH_RD) begin
                        state_next = CHECK;
                    end else if (cfg_verify) begin
                        phase_next = PH_RD;
                        issue      = 1'b1;
                        state_next = ISSUE;
                    end else begin
                        idx_next   = idx + 4'd1;
                        state_next = SELECT;
                    end
                end else if (tcnt >= T_LIMIT) begin
                    fail       = 1'b1;
                    fail_code  = ERR_TIMEOUT;
                    state_next = FINISH;
                end else begin
                    tcnt_inc = 1'b1;
                end
            end
            CHECK: begin
                if (ctrl.read_data == reg_image(cfg_image, idx[2:0])) begin
                    idx_next   = idx + 4'd1;
                    state_next = SELECT;
                end else begin
                    fail       = 1'b1;
                    fail_code  = ERR_MISMATCH;
                    state_next = FINISH;
                end
            end
            FINISH: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Latch the job, run the watchdog counters and hold the sticky status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed      <= 1'b0;
            idx        <= 4'd0;
            phase      <= PH_WR;
            cfg_image  <= '0;
            cfg_mask   <= '0;
            cfg_verify <= 1'b0;
            tcnt       <= '0;
            ack_cnt    <= '0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            error_o    <= ERR_NONE;
            err_addr_o <= 3'd0;
        end else begin
            armed  <= 1'b1;
            idx    <= idx_next;
            phase  <= phase_next;
            done_o <= (state_next == FINISH);
            if (load_cfg) begin
                cfg_image  <= cfg_data_i;
                cfg_mask   <= cfg_mask_i;
                cfg_verify <= verify_i;
                busy_o     <= 1'b1;
                error_o    <= ERR_NONE;
                err_addr_o <= 3'd0;
            end else if (state == FINISH) begin
                busy_o <= 1'b0;
            end
            if (fail) begin
                error_o    <= fail_code;
                err_addr_o <= idx[2:0];
            end
            if (issue) begin
                tcnt    <= '0;
                ack_cnt <= '0;
            end else begin
                if (tcnt_inc && tcnt != T_SAT) begin
                    tcnt <= tcnt + 1'b1;
                end
                if (ack_inc) begin
                    ack_cnt <= ack_cnt + 1'b1;
                end
            end
        end
    end

    // Drive the controller request: one-cycle pulse, address/data held until the next issue
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl.address     <= 3'd0;
            ctrl.write_data  <= 9'd0;
            ctrl.write_valid <= 1'b0;
            ctrl.read_start  <= 1'b0;
        end else begin
            ctrl.write_valid <= issue && (phase_next == PH_WR);
            ctrl.read_start  <= issue && (phase_next == PH_RD);
            if (issue) begin
                ctrl.address    <= idx[2:0];
                ctrl.write_data <= (phase_next == PH_WR) ? reg_image(cfg_image, idx[2:0]) : 9'd0;
            end
        end
    end

endmodule

// File: tb/tb_ad9826_config_sequencer.sv
// Directed bench for the AD9826 configuration sequencer, with a behavioural
// serial controller + register file standing in for the SPI path.
module tb_ad9826_config_sequencer;
    import ad9826_config_sequencer_pkg::*;

    localparam int T_CYC    = 64;
    localparam int XFER_LEN = 6;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_i;
    logic [71:0] cfg_data_i;
    logic [7:0]  cfg_mask_i;
    logic        verify_i;
    logic        busy_o;
    logic        done_o;
    logic [1:0]  error_o;
    logic [2:0]  err_addr_o;

    ad9826_config_sequencer_if ctrl_bus ();

    ad9826_config_sequencer #(
        .AUTO_START  (1),
        .TIMEOUT_CYC (T_CYC),
        .ACK_CYC     (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_i    (start_i),
        .cfg_data_i (cfg_data_i),
        .cfg_mask_i (cfg_mask_i),
        .verify_i   (verify_i),
        .ctrl       (ctrl_bus),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .error_o    (error_o),
        .err_addr_o (err_addr_o)
    );

    always #5 clk = ~clk;

    logic       m_busy  = 1'b0;
    int         m_left  = 0;
    logic [2:0] m_addr  = 3'd0;
    logic [8:0] m_wdata = 9'd0;
    logic [8:0] m_rdata = 9'd0;
    logic       m_rd    = 1'b0;
    logic [8:0] mregs [8];
    logic [2:0] wr_log [256];
    int         wr_cnt      = 0;
    int         rd_cnt      = 0;
    int         overlap_cnt = 0;
    int         done_cnt    = 0;
    bit         stuck_en    = 1'b0;
    bit         corrupt_en  = 1'b0;
    logic [2:0] stuck_addr   = 3'd0;
    logic [2:0] corrupt_addr = 3'd0;

    int checks   = 0;
    int failures = 0;

    assign ctrl_bus.busy      = m_busy;
    assign ctrl_bus.read_data = m_rdata;

    // Serial controller stand-in: busy rises the edge after a request, lasts XFER_LEN+1 cycles
    always @(posedge clk) begin
        if (m_busy) begin
            if (ctrl_bus.write_valid || ctrl_bus.read_start) begin
                overlap_cnt <= overlap_cnt + 1;
            end
            if (m_left != 0) begin
                m_left <= m_left - 1;
            end else if (!(stuck_en && m_addr == stuck_addr)) begin
                m_busy <= 1'b0;
                if (m_rd) begin
                    m_rdata <= (corrupt_en && m_addr == corrupt_addr) ? 9'h0AA : mregs[m_addr];
                end else begin
                    mregs[m_addr] <= m_wdata;
                end
            end
        end else if (ctrl_bus.write_valid || ctrl_bus.read_start) begin
            m_busy  <= 1'b1;
            m_left  <= XFER_LEN;
            m_addr  <= ctrl_bus.address;
            m_wdata <= ctrl_bus.write_data;
            m_rd    <= ctrl_bus.read_start;
            if (ctrl_bus.write_valid) begin
                wr_log[wr_cnt[7:0]] <= ctrl_bus.address;
                wr_cnt <= wr_cnt + 1;
            end else begin
                rd_cnt <= rd_cnt + 1;
            end
        end
    end

    // Count done pulses away from the active edge
    always @(negedge clk) begin
        if (done_o) begin
            done_cnt <= done_cnt + 1;
        end
    end

    task automatic checkOutput(input string tag, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] mask, input logic verify, input logic [8:0] base);
        for (int k = 0; k < 8; k++) begin
            cfg_data_i[9*k +: 9] = base + 9'(k);
        end
        cfg_mask_i = mask;
        verify_i   = verify;
        start_i    = 1'b1;
        tick();
        start_i    = 1'b0;
    endtask

    task automatic waitDone(input string tag, input int budget, output int cycles);
        cycles = 1;
        while (!done_o && cycles < budget) begin
            tick();
            cycles++;
        end
        checkOutput(tag, int'(done_o), 1);
    endtask

    task automatic writeOrder(input int base, output int order);
        order = 0;
        for (int i = 0; i < 8; i++) begin
            order = order | (int'(wr_log[8'(base + i)]) << (3 * i));
        end
    endtask

    initial begin
        int cyc;
        int wr_snap;
        int rd_snap;
        int done_snap;
        int order;
        int k;

        rst_n      = 1'b1;
        start_i    = 1'b0;
        cfg_data_i = '0;
        cfg_mask_i = 8'h00;
        verify_i   = 1'b0;

        $display("[TB] reset and boot sequence");
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_status", int'({busy_o, done_o, error_o, err_addr_o}), 0);
        checkOutput("rst_ctrl", int'({ctrl_bus.address, ctrl_bus.write_data,
                                      ctrl_bus.write_valid, ctrl_bus.read_start}), 0);
        repeat (3) tick();
        wr_snap = wr_cnt;
        rst_n   = 1'b1;
        waitDone("boot_done", 60, cyc);
        checkOutput("boot_no_writes", wr_cnt - wr_snap, 0);
        checkOutput("boot_error", int'(error_o), int'(ERR_NONE));
        repeat (3) tick();

        $display("[TB] full write, no verify");
        wr_snap = wr_cnt; rd_snap = rd_cnt; done_snap = done_cnt;
        applyStimulus(8'hFF, 1'b0, 9'h100);
        waitDone("t1_done", 400, cyc);
        tick();
        checkOutput("t1_writes", wr_cnt - wr_snap, 8);
        checkOutput("t1_reads", rd_cnt - rd_snap, 0);
        writeOrder(wr_snap, order);
        checkOutput("t1_order", order, 24'o76543210);
        checkOutput("t1_done_once", done_cnt - done_snap, 1);
        checkOutput("t1_error", int'(error_o), int'(ERR_NONE));
        for (int r = 0; r < 8; r++) begin
            checkOutput($sformatf("t1_reg%0d", r), int'(mregs[r]), 32'h100 + r);
        end
        repeat (2) tick();

        $display("[TB] sparse mask with verify");
        wr_snap = wr_cnt; rd_snap = rd_cnt;
        applyStimulus(8'h05, 1'b1, 9'h0A0);
        waitDone("t2_done", 400, cyc);
        tick();
        checkOutput("t2_writes", wr_cnt - wr_snap, 2);
        checkOutput("t2_reads", rd_cnt - rd_snap, 2);
        checkOutput("t2_error", int'(error_o), int'(ERR_NONE));
        checkOutput("t2_reg0", int'(mregs[0]), 32'h0A0);
        checkOutput("t2_reg1_kept", int'(mregs[1]), 32'h101);
        checkOutput("t2_reg2", int'(mregs[2]), 32'h0A2);
        repeat (2) tick();

        $display("[TB] readback mismatch on addr 3");
        corrupt_en = 1'b1; corrupt_addr = 3'd3;
        wr_snap = wr_cnt; rd_snap = rd_cnt; done_snap = done_cnt;
        applyStimulus(8'hFF, 1'b1, 9'h050);
        waitDone("t3_done", 600, cyc);
        tick();
        corrupt_en = 1'b0;
        checkOutput("t3_writes", wr_cnt - wr_snap, 4);
        checkOutput("t3_reads", rd_cnt - rd_snap, 4);
        checkOutput("t3_error", int'(error_o), int'(ERR_MISMATCH));
        checkOutput("t3_err_addr", int'(err_addr_o), 3);
        checkOutput("t3_reg4_kept", int'(mregs[4]), 32'h104);
        checkOutput("t3_done_once", done_cnt - done_snap, 1);
        repeat (2) tick();

        $display("[TB] controller stuck busy on addr 1");
        stuck_en = 1'b1; stuck_addr = 3'd1;
        done_snap = done_cnt;
        applyStimulus(8'hFF, 1'b0, 9'h140);
        k = 0;
        while (!(ctrl_bus.busy && ctrl_bus.address == 3'd1) && k < 100) begin
            tick();
            k++;
        end
        checkOutput("t4_reach_addr1", int'(ctrl_bus.busy && ctrl_bus.address == 3'd1), 1);
        k = 0;
        while (error_o == 2'b00 && k < 4 * T_CYC) begin
            tick();
            k++;
        end
        checkOutput("t4_timeout_window", int'(k >= T_CYC - 1 && k <= T_CYC + 1), 1);
        checkOutput("t4_error", int'(error_o), int'(ERR_TIMEOUT));
        checkOutput("t4_err_addr", int'(err_addr_o), 1);
        repeat (2) tick();
        checkOutput("t4_done_once", done_cnt - done_snap, 1);
        stuck_en = 1'b0;
        repeat (4) tick();
        applyStimulus(8'h01, 1'b1, 9'h1C0);
        checkOutput("t4_error_cleared", int'(error_o), int'(ERR_NONE));
        waitDone("t4_rerun_done", 200, cyc);
        checkOutput("t4_rerun_error", int'(error_o), int'(ERR_NONE));
        tick();
        checkOutput("t4_rerun_reg0", int'(mregs[0]), 32'h1C0);
        repeat (2) tick();

        $display("[TB] start while busy and in the done cycle");
        wr_snap = wr_cnt; done_snap = done_cnt;
        applyStimulus(8'hFF, 1'b0, 9'h180);
        repeat (5) tick();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        waitDone("t5_done", 400, cyc);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        repeat (3) tick();
        checkOutput("t5_idle_after_done", int'(busy_o), 0);
        checkOutput("t5_writes", wr_cnt - wr_snap, 8);
        checkOutput("t5_done_once", done_cnt - done_snap, 1);

        wr_snap = wr_cnt; rd_snap = rd_cnt;
        applyStimulus(8'h00, 1'b0, 9'h000);
        waitDone("t5_mask0_done", 40, cyc);
        checkOutput("t5_mask0_latency", cyc, 10);
        tick();
        checkOutput("t5_mask0_no_spi", (wr_cnt - wr_snap) + (rd_cnt - rd_snap), 0);
        repeat (2) tick();

        $display("[TB] reset during addr 4 transfer, auto rerun");
        applyStimulus(8'hFF, 1'b0, 9'h1F0);
        k = 0;
        while (!(ctrl_bus.busy && ctrl_bus.address == 3'd4) && k < 200) begin
            tick();
            k++;
        end
        checkOutput("t6_reach_addr4", int'(ctrl_bus.busy && ctrl_bus.address == 3'd4), 1);
        done_snap = done_cnt;
        #2 rst_n = 1'b0;
        #1;
        checkOutput("t6_async_status", int'({busy_o, done_o, error_o, err_addr_o}), 0);
        checkOutput("t6_async_ctrl", int'({ctrl_bus.address, ctrl_bus.write_data,
                                           ctrl_bus.write_valid, ctrl_bus.read_start}), 0);
        repeat (2) tick();
        checkOutput("t6_no_done", done_cnt - done_snap, 0);
        wr_snap = wr_cnt;
        rst_n   = 1'b1;
        tick();
        checkOutput("t6_boot_wait", int'(busy_o), 0);
        tick();
        checkOutput("t6_boot_busy", int'(busy_o), 1);
        waitDone("t6_rerun_done", 400, cyc);
        tick();
        checkOutput("t6_rerun_writes", wr_cnt - wr_snap, 8);
        writeOrder(wr_snap, order);
        checkOutput("t6_rerun_order", order, 24'o76543210);
        checkOutput("t6_rerun_error", int'(error_o), int'(ERR_NONE));
        checkOutput("t6_reg4", int'(mregs[4]), 32'h1F4);
        checkOutput("t6_reg7", int'(mregs[7]), 32'h1F7);
        checkOutput("no_overlapping_requests", overlap_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
